// File: rtl/axi4lite_sub_regs.sv
// AXI4-Lite subordinate register file: independent write (AW/W/B) and read (AR/R)
// FSMs over a bank of 32-bit registers, with read-only slots backed by ro_data.
module axi4lite_sub_regs #(
    parameter int                  C_S_AXI_ADDR_WIDTH = 6,
    parameter int                  NUM_REGS           = 12,
    parameter logic [NUM_REGS-1:0] RO_MASK            = 12'h0F0
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [2:0]                    S_AXI_AWPROT,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [31:0]                   S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [2:0]                    S_AXI_ARPROT,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [31:0]                   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    input  logic [32*NUM_REGS-1:0]        ro_data,
    output logic [32*NUM_REGS-1:0]        reg_out,
    output logic [NUM_REGS-1:0]           wr_pulse,
    output logic [1:0]                    wr_state_dbg,
    output logic                          rd_state_dbg
);
    localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_RESP}         r_state_t;

    w_state_t            w_state;
    r_state_t            r_state;
    logic [IW-1:0]       waddr_idx;
    logic [IW-1:0]       r_idx;
    logic [31:0]         regs [NUM_REGS];
    logic [NUM_REGS-1:0] w_hit;
    logic                w_in_range;
    logic                w_is_ro;
    logic                r_in_range;
    logic [31:0]         r_word;
    logic                unused_bits;

    // A transfer happens on every rising edge where VALID and READY are both high;
    // VALID/READY and payload are registered and held until that edge.
    assign wr_state_dbg = w_state;
    assign rd_state_dbg = r_state;
    assign r_idx        = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign unused_bits  = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                            S_AXI_ARADDR[1:0], ro_data};

    always_comb begin
        w_hit      = '0;
        w_in_range = 1'b0;
        w_is_ro    = 1'b0;
        r_in_range = 1'b0;
        r_word     = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (waddr_idx == IW'(i)) begin
                w_hit[i]   = 1'b1;
                w_in_range = 1'b1;
                w_is_ro    = RO_MASK[i];
            end
            if (r_idx == IW'(i)) begin
                r_in_range = 1'b1;
                r_word     = RO_MASK[i] ? ro_data[32*i +: 32] : regs[i];
            end
        end
    end

    always_comb begin
        reg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_out[32*i +: 32] = RO_MASK[i] ? 32'h0 : regs[i];
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            w_state       <= W_IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
            waddr_idx     <= '0;
            wr_pulse      <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            wr_pulse <= '0;
            case (w_state)
                W_IDLE: begin
                    if (S_AXI_AWREADY && S_AXI_AWVALID) begin
                        waddr_idx     <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
                        S_AXI_AWREADY <= 1'b0;
                        S_AXI_WREADY  <= 1'b1;
                        w_state       <= W_DATA;
                    end else begin
                        S_AXI_AWREADY <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (S_AXI_WVALID) begin
                        S_AXI_WREADY <= 1'b0;
                        S_AXI_BVALID <= 1'b1;
                        w_state      <= W_RESP;
                        if (!w_in_range) begin
                            S_AXI_BRESP <= RESP_DECERR;
                        end else if (w_is_ro) begin
                            S_AXI_BRESP <= RESP_SLVERR;
                        end else begin
                            S_AXI_BRESP <= RESP_OKAY;
                            wr_pulse    <= w_hit;
                            for (int i = 0; i < NUM_REGS; i++) begin
                                for (int b = 0; b < 4; b++) begin
                                    if (w_hit[i] && S_AXI_WSTRB[b])
                                        regs[i][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                                end
                            end
                        end
                    end
                end
                W_RESP: begin
                    // AWREADY comes back together with the B handshake.
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID  <= 1'b0;
                        S_AXI_BRESP   <= RESP_OKAY;
                        S_AXI_AWREADY <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_state       <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (S_AXI_ARREADY && S_AXI_ARVALID) begin
                        S_AXI_ARREADY <= 1'b0;
                        S_AXI_RVALID  <= 1'b1;
                        S_AXI_RDATA   <= r_word;
                        S_AXI_RRESP   <= r_in_range ? RESP_OKAY : RESP_DECERR;
                        r_state       <= R_RESP;
                    end else begin
                        S_AXI_ARREADY <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (S_AXI_RREADY) begin
                        S_AXI_RVALID  <= 1'b0;
                        S_AXI_RDATA   <= '0;
                        S_AXI_RRESP   <= RESP_OKAY;
                        S_AXI_ARREADY <= 1'b1;
                        r_state       <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule
